maze_grid_ctrl: RTL and testbench

MAZE_GRID_CTRL -- requirements
Module: maze_grid_ctrl

---
 rtl/maze_pkg.sv | 29 ++
 rtl/grid_arbiter.sv | 42 ++++
 rtl/maze_grid_ctrl.sv | 148 ++++++++++++++
 tb/tb_maze_grid_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared constants for the maze grid controller: cell states, grid size defaults,
// position packet field layout and FSM state encoding.
package maze_pkg;

  localparam int DEF_ROWS = 4;
  localparam int DEF_COLS = 5;

  localparam int PKT_ROW_LSB = 0;
  localparam int PKT_ROW_MSB = 1;
  localparam int PKT_COL_LSB = 2;
  localparam int PKT_COL_MSB = 4;

  localparam logic [1:0] CELL_UNVISITED = 2'd0;
  localparam logic [1:0] CELL_VISITED   = 2'd1;
  localparam logic [1:0] CELL_CURRENT   = 2'd2;
  localparam logic [1:0] CELL_FUTURE    = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_OLD = 2'd1,
    WR_NEW = 2'd2,
    CLEAR  = 2'd3
  } grid_state_t;

  function automatic int cell_index(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/grid_arbiter.sv
// Shares the single grid access slot between the VGA reader and the FSM writer;
// reads win until the writer has stalled STARVE_MAX cycles in a row.
module grid_arbiter #(
  parameter int STARVE_MAX = 15
) (
  input  logic CLOCK,
  input  logic RESET_N,
  input  logic rd_en,
  input  logic wr_req,
  output logic wr_gnt,
  output logic rd_take,
  output logic rd_gnt
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] stall_cnt_r;
  logic             force_s;

  // Slot decision for the current cycle
  always_comb begin
    force_s = wr_req && rd_en && (stall_cnt_r == CNT_W'(STARVE_MAX));
    wr_gnt  = wr_req && (!rd_en || force_s);
    rd_take = rd_en && !force_s;
  end

  // Stall counter and registered read grant
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      rd_gnt      <= 1'b0;
    end else begin
      rd_gnt <= rd_take;
      if (wr_gnt || !wr_req) begin
        stall_cnt_r <= {CNT_W{1'b0}};
      end else begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/maze_grid_ctrl.sv
// Robot maze grid: tracks visited/current cells from position packets and serves VGA reads.
// Define GRID_DUP_FILTER_EN to swallow packets that repeat the current position.
module maze_grid_ctrl import maze_pkg::*; #(
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int STARVE_MAX = 15
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic [4:0] PKT_IN,
  input  logic       PKT_VALID,
  output logic       PKT_READY,
  input  logic       CLEAR_REQ,
  input  logic       RD_EN,
  input  logic [1:0] RD_ROW,
  input  logic [2:0] RD_COL,
  output logic [1:0] RD_DATA,
  output logic       RD_GNT,
  output logic [4:0] CUR_POS,
  output logic       HAVE_POS,
  output logic       BUSY,
  output logic       ERR_BAD_PKT
);

  localparam int CELLS = ROWS * COLS;
  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  grid_state_t      state_r;
  logic [1:0]       cells_r [CELLS];
  logic [4:0]       pkt_r;
  logic [4:0]       cur_pos_r;
  logic             have_pos_r;
  logic             err_r;
  logic             ready_r;
  logic [IDX_W-1:0] clr_idx_r;
  logic [1:0]       rd_data_r;

  logic             pkt_ok_s;
  logic             take_pkt_s;
  logic             accept_s;
  logic [IDX_W-1:0] new_idx_s;
  logic [IDX_W-1:0] old_idx_s;
  logic             rd_ok_s;
  logic [IDX_W-1:0] rd_idx_s;
  logic [1:0]       rd_cell_s;
  logic             wr_req_s;
  logic             wr_gnt_s;
  logic             rd_take_s;

  // Packet decode, cell addressing and handshake
  always_comb begin
    pkt_ok_s = (int'(PKT_IN[PKT_ROW_MSB:PKT_ROW_LSB]) < ROWS) &&
               (int'(PKT_IN[PKT_COL_MSB:PKT_COL_LSB]) < COLS);
`ifdef GRID_DUP_FILTER_EN
    take_pkt_s = pkt_ok_s && !(have_pos_r && (PKT_IN == cur_pos_r));
`else
    take_pkt_s = pkt_ok_s;
`endif
    PKT_READY = ready_r && (state_r == IDLE) && !CLEAR_REQ;
    accept_s  = PKT_VALID && PKT_READY;
    new_idx_s = IDX_W'(cell_index(int'(pkt_r[PKT_ROW_MSB:PKT_ROW_LSB]),
                                  int'(pkt_r[PKT_COL_MSB:PKT_COL_LSB]), COLS));
    old_idx_s = IDX_W'(cell_index(int'(cur_pos_r[PKT_ROW_MSB:PKT_ROW_LSB]),
                                  int'(cur_pos_r[PKT_COL_MSB:PKT_COL_LSB]), COLS));
    rd_ok_s   = (int'(RD_ROW) < ROWS) && (int'(RD_COL) < COLS);
    rd_idx_s  = IDX_W'(cell_index(int'(RD_ROW), int'(RD_COL), COLS));
    rd_cell_s = rd_ok_s ? cells_r[rd_idx_s] : CELL_UNVISITED;
    wr_req_s  = (state_r != IDLE);
  end

  assign BUSY        = (state_r != IDLE);
  assign RD_DATA     = rd_data_r;
  assign CUR_POS     = cur_pos_r;
  assign HAVE_POS    = have_pos_r;
  assign ERR_BAD_PKT = err_r;

  grid_arbiter #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .rd_en   (RD_EN),
    .wr_req  (wr_req_s),
    .wr_gnt  (wr_gnt_s),
    .rd_take (rd_take_s),
    .rd_gnt  (RD_GNT)
  );

  // Grid FSM, cell storage and read data register
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_r    <= IDLE;
      for (int i = 0; i < CELLS; i++) cells_r[i] <= CELL_UNVISITED;
      pkt_r      <= 5'd0;
      cur_pos_r  <= 5'd0;
      have_pos_r <= 1'b0;
      err_r      <= 1'b0;
      ready_r    <= 1'b0;
      clr_idx_r  <= {IDX_W{1'b0}};
      rd_data_r  <= 2'd0;
    end else begin
      ready_r <= 1'b1;
      if (rd_take_s) rd_data_r <= rd_cell_s;
      case (state_r)
        IDLE: begin
          if (CLEAR_REQ) begin
            clr_idx_r <= {IDX_W{1'b0}};
            state_r   <= CLEAR;
          end else if (accept_s) begin
            if (!pkt_ok_s) begin
              err_r <= 1'b1;
            end else if (take_pkt_s) begin
              pkt_r   <= PKT_IN;
              state_r <= have_pos_r ? WR_OLD : WR_NEW;
            end
          end
        end
        WR_OLD: begin
          if (wr_gnt_s) begin
            cells_r[old_idx_s] <= CELL_VISITED;
            state_r            <= WR_NEW;
          end
        end
        WR_NEW: begin
          if (wr_gnt_s) begin
            cells_r[new_idx_s] <= CELL_CURRENT;
            cur_pos_r          <= pkt_r;
            have_pos_r         <= 1'b1;
            state_r            <= IDLE;
          end
        end
        CLEAR: begin
          if (wr_gnt_s) begin
            cells_r[clr_idx_r] <= CELL_UNVISITED;
            if (clr_idx_r == IDX_W'(CELLS - 1)) begin
              have_pos_r <= 1'b0;
              cur_pos_r  <= 5'd0;
              err_r      <= 1'b0;
              state_r    <= IDLE;
            end else begin
              clr_idx_r <= clr_idx_r + IDX_W'(1);
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_grid_ctrl.sv
// Directed self-checking bench for maze_grid_ctrl (default 4x5 grid, STARVE_MAX 15).
module tb_maze_grid_ctrl;

  logic       CLOCK;
  logic       RESET_N;
  logic [4:0] PKT_IN;
  logic       PKT_VALID;
  logic       PKT_READY;
  logic       CLEAR_REQ;
  logic       RD_EN;
  logic [1:0] RD_ROW;
  logic [2:0] RD_COL;
  logic [1:0] RD_DATA;
  logic       RD_GNT;
  logic [4:0] CUR_POS;
  logic       HAVE_POS;
  logic       BUSY;
  logic       ERR_BAD_PKT;

  int errors = 0;
  int checks = 0;

  maze_grid_ctrl dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .PKT_IN(PKT_IN), .PKT_VALID(PKT_VALID),
    .PKT_READY(PKT_READY), .CLEAR_REQ(CLEAR_REQ), .RD_EN(RD_EN), .RD_ROW(RD_ROW),
    .RD_COL(RD_COL), .RD_DATA(RD_DATA), .RD_GNT(RD_GNT), .CUR_POS(CUR_POS),
    .HAVE_POS(HAVE_POS), .BUSY(BUSY), .ERR_BAD_PKT(ERR_BAD_PKT)
  );

  initial CLOCK = 1'b0;
  always #20 CLOCK = ~CLOCK;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task tick;
    @(posedge CLOCK);
    #1;
  endtask

  task wait_idle(input string tag, output int n);
    n = 0;
    while (BUSY === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL %s_timeout: BUSY still %b after %0d cycles, required 0", tag, BUSY, n);
    end
  endtask

  task send_pkt(input logic [4:0] p, output int busy_cycles);
    PKT_IN = p; PKT_VALID = 1'b1;
    tick();
    PKT_VALID = 1'b0;
    wait_idle("send", busy_cycles);
  endtask

  task pulse_clear;
    CLEAR_REQ = 1'b1;
    tick();
    CLEAR_REQ = 1'b0;
  endtask

  task read_cell(input logic [1:0] r, input logic [2:0] c, output logic [1:0] d, output logic g);
    RD_EN = 1'b1; RD_ROW = r; RD_COL = c;
    tick();
    d = RD_DATA; g = RD_GNT;
    RD_EN = 1'b0;
  endtask

  task test_reset;
    logic [1:0] d; logic g;
    RESET_N = 1'b0; PKT_IN = 5'd0; PKT_VALID = 1'b0; CLEAR_REQ = 1'b0;
    RD_EN = 1'b0; RD_ROW = 2'd0; RD_COL = 3'd0;
    tick(); tick();
    checks++;
    if ({PKT_READY, RD_GNT, RD_DATA, CUR_POS, HAVE_POS, BUSY, ERR_BAD_PKT} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required all zero",
               {PKT_READY, RD_GNT, RD_DATA, CUR_POS, HAVE_POS, BUSY, ERR_BAD_PKT});
    end
    RESET_N = 1'b1;
    tick();
    checks++; if (PKT_READY !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", PKT_READY); end
    read_cell(2'd3, 3'd4, d, g);
    checks++; if ({g, d} !== 3'b100) begin errors++; $display("FAIL reset_cell: got gnt/data %b required 100", {g, d}); end
  endtask

  task test_path;
    int n; logic [1:0] d; logic g;
    send_pkt(5'b00000, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL path_first_busy: got %0d required 1", n); end
    send_pkt(5'b00101, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL path_move_busy: got %0d required 2", n); end
    checks++; if ({HAVE_POS, CUR_POS} !== 6'b100101) begin errors++; $display("FAIL path_pos: got %b required 100101", {HAVE_POS, CUR_POS}); end
    read_cell(2'd0, 3'd0, d, g);
    checks++; if ({g, d} !== 3'b101) begin errors++; $display("FAIL path_cell00: got %b required 101", {g, d}); end
    read_cell(2'd1, 3'd1, d, g);
    checks++; if ({g, d} !== 3'b110) begin errors++; $display("FAIL path_cell11: got %b required 110", {g, d}); end
    tick();
    checks++; if ({RD_GNT, RD_DATA} !== 3'b010) begin errors++; $display("FAIL path_rd_hold: got %b required 010", {RD_GNT, RD_DATA}); end
    read_cell(2'd3, 3'd7, d, g);
    checks++; if ({g, d} !== 3'b100) begin errors++; $display("FAIL path_rd_oob: got %b required 100", {g, d}); end
  endtask

  task test_bad_pkt;
    int n; logic [1:0] d; logic g;
    send_pkt(5'b10100, n);
    checks++; if (n !== 0) begin errors++; $display("FAIL bad_busy: got %0d required 0", n); end
    checks++; if ({ERR_BAD_PKT, CUR_POS} !== 6'b100101) begin errors++; $display("FAIL bad_err_pos: got %b required 100101", {ERR_BAD_PKT, CUR_POS}); end
    send_pkt(5'b11111, n);
    checks++; if ({n[1:0], ERR_BAD_PKT} !== 3'b001) begin errors++; $display("FAIL bad_col7: got busy %0d err %b required 0/1", n, ERR_BAD_PKT); end
    read_cell(2'd1, 3'd1, d, g);
    checks++; if (d !== 2'd2) begin errors++; $display("FAIL bad_grid_kept: got %0d required 2", d); end
    pulse_clear();
    wait_idle("clear", n);
    checks++; if (n !== 20) begin errors++; $display("FAIL clear_cycles: got %0d required 20", n); end
    checks++; if ({ERR_BAD_PKT, HAVE_POS, CUR_POS, PKT_READY} !== 8'b00000001) begin
      errors++; $display("FAIL clear_state: got %b required 00000001", {ERR_BAD_PKT, HAVE_POS, CUR_POS, PKT_READY});
    end
    read_cell(2'd1, 3'd1, d, g);
    checks++; if (d !== 2'd0) begin errors++; $display("FAIL clear_cell11: got %0d required 0", d); end
  endtask

  task test_clear_vs_pkt;
    int n; logic [1:0] d; logic g;
    send_pkt(5'b01010, n);
    CLEAR_REQ = 1'b1; PKT_VALID = 1'b1; PKT_IN = 5'b00001;
    #1;
    checks++; if (PKT_READY !== 1'b0) begin errors++; $display("FAIL cvp_ready: got %b required 0", PKT_READY); end
    tick();
    CLEAR_REQ = 1'b0; PKT_VALID = 1'b0;
    wait_idle("cvp", n);
    checks++; if (n !== 20) begin errors++; $display("FAIL cvp_cycles: got %0d required 20", n); end
    checks++; if ({HAVE_POS, PKT_READY} !== 2'b01) begin errors++; $display("FAIL cvp_state: got %b required 01", {HAVE_POS, PKT_READY}); end
    read_cell(2'd2, 3'd2, d, g);
    checks++; if (d !== 2'd0) begin errors++; $display("FAIL cvp_cell22: got %0d required 0", d); end
  endtask

  task test_starve;
    int n; int zeros; logic [1:0] d; logic g;
    logic gh [40]; logic bh [40]; logic [1:0] dh [40];
    send_pkt(5'b00000, n);
    RD_EN = 1'b1; RD_ROW = 2'd0; RD_COL = 3'd0; PKT_IN = 5'b00110; PKT_VALID = 1'b1;
    #1;
    checks++; if (PKT_READY !== 1'b1) begin errors++; $display("FAIL starve_ready: got %b required 1", PKT_READY); end
    for (int k = 0; k < 40; k++) begin
      tick();
      PKT_VALID = 1'b0;
      gh[k] = RD_GNT; bh[k] = BUSY; dh[k] = RD_DATA;
    end
    RD_EN = 1'b0;
    zeros = 0;
    for (int k = 0; k < 40; k++) if (gh[k] !== 1'b1) zeros++;
    checks++; if (zeros !== 2) begin errors++; $display("FAIL starve_gnt_drops: got %0d required 2", zeros); end
    checks++; if ({gh[15], gh[16], gh[17], gh[31], gh[32], gh[33]} !== 6'b101101) begin
      errors++; $display("FAIL starve_gnt_pattern: got %b required 101101", {gh[15], gh[16], gh[17], gh[31], gh[32], gh[33]});
    end
    checks++; if ({bh[15], bh[16], bh[31], bh[32]} !== 4'b1110) begin
      errors++; $display("FAIL starve_busy: got %b required 1110", {bh[15], bh[16], bh[31], bh[32]});
    end
    checks++; if ({dh[15], dh[16], dh[17]} !== 6'b101001) begin
      errors++; $display("FAIL starve_rd_data: got %b required 101001", {dh[15], dh[16], dh[17]});
    end
    checks++; if (CUR_POS !== 5'b00110) begin errors++; $display("FAIL starve_pos: got %b required 00110", CUR_POS); end
    read_cell(2'd2, 3'd1, d, g);
    checks++; if (d !== 2'd2) begin errors++; $display("FAIL starve_cell21: got %0d required 2", d); end
  endtask

  task test_reset_mid_clear;
    int n; logic [1:0] d; logic g;
    send_pkt(5'b01111, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL rmc_setup_busy: got %0d required 2", n); end
    pulse_clear();
    repeat (7) tick();
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL rmc_busy_mid: got %b required 1", BUSY); end
    RESET_N = 1'b0;
    tick();
    checks++; if ({BUSY, HAVE_POS, PKT_READY} !== 3'b000) begin errors++; $display("FAIL rmc_in_reset: got %b required 000", {BUSY, HAVE_POS, PKT_READY}); end
    RESET_N = 1'b1;
    tick();
    checks++; if ({PKT_READY, CUR_POS} !== 6'b100000) begin errors++; $display("FAIL rmc_release: got %b required 100000", {PKT_READY, CUR_POS}); end
    read_cell(2'd3, 3'd3, d, g);
    checks++; if (d !== 2'd0) begin errors++; $display("FAIL rmc_cell33: got %0d required 0", d); end
    read_cell(2'd2, 3'd1, d, g);
    checks++; if (d !== 2'd0) begin errors++; $display("FAIL rmc_cell21: got %0d required 0", d); end
  endtask

  task test_dup;
    int n; int exp_busy; logic [1:0] d; logic g;
`ifdef GRID_DUP_FILTER_EN
    exp_busy = 0;
`else
    exp_busy = 2;
`endif
    send_pkt(5'b01000, n);
    send_pkt(5'b01000, n);
    checks++; if (n !== exp_busy) begin errors++; $display("FAIL dup_busy: got %0d required %0d", n, exp_busy); end
    checks++; if ({HAVE_POS, CUR_POS} !== 6'b101000) begin errors++; $display("FAIL dup_pos: got %b required 101000", {HAVE_POS, CUR_POS}); end
    read_cell(2'd0, 3'd2, d, g);
    checks++; if ({g, d} !== 3'b110) begin errors++; $display("FAIL dup_cell02: got %b required 110", {g, d}); end
  endtask

  initial begin
    test_reset();
    test_path();
    test_bad_pkt();
    test_clear_vs_pkt();
    test_starve();
    test_reset_mid_clear();
    test_dup();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
